// File: rtl/branch_resolve_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve_if                                            |
// | Description : Fetch <-> branch-resolve bus: decoded instruction in,        |
// |               redirect / issue / hazard status out.                        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface branch_resolve_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
);
    logic            validIn;
    logic [31:0]     pcIn;
    logic [11:0]     code;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            isLoad;
    logic            isBranch;
    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic            loadDone;
    logic [4:0]      loadRd;
    logic            originPc;
    logic [31:0]     pcBranch;
    logic            stall;
    logic            issueValid;
    logic [31:0]     linkValue;
    logic [CNTW-1:0] redirectCount;

    modport master (
        output validIn, pcIn, code, imm, rd, rs1, rs2, isLoad, isBranch,
               rs1Val, rs2Val, loadDone, loadRd,
        input  originPc, pcBranch, stall, issueValid, linkValue, redirectCount
    );

    modport slave (
        input  validIn, pcIn, code, imm, rd, rs1, rs2, isLoad, isBranch,
               rs1Val, rs2Val, loadDone, loadRd,
        output originPc, pcBranch, stall, issueValid, linkValue, redirectCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve                                               |
// | Description : Resolves branches/jumps, redirects fetch, squashes the       |
// |               wrong path and stalls on load-use hazards.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 1,
    parameter int CNTW         = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    branch_resolve_if.slave bus
);
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [1:0] c_SQUASH_LOAD = 2'(SQUASH_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_squash_cnt;
    logic [31:0]     r_sb;
    logic            r_issue;
    logic            r_origin;
    logic [31:0]     r_pc_branch;
    logic [31:0]     r_link;
    logic [CNTW-1:0] r_count;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_jalr_sum;
    logic [31:0]     w_target;
    logic            w_stall;
    logic            w_accept;
    logic [31:0]     w_sb_next;
    logic            w_unused;

    assign w_opcode   = bus.code[6:0];
    assign w_funct3   = bus.code[9:7];
    assign w_eq       = (bus.rs1Val == bus.rs2Val);
    assign w_lt       = ($signed(bus.rs1Val) < $signed(bus.rs2Val));
    assign w_ltu      = (bus.rs1Val < bus.rs2Val);
    assign w_unused   = &{1'b0, bus.isBranch, bus.code[11:10]};

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken    = ((w_opcode == c_OP_BRANCH) & w_cond)
                      | (w_opcode == c_OP_JAL)
                      | (w_opcode == c_OP_JALR);
    assign w_jalr_sum = bus.rs1Val + bus.imm;
    assign w_target   = (w_opcode == c_OP_JALR) ? {w_jalr_sum[31:1], 1'b0}
                                                : (bus.pcIn + bus.imm[31:0]);

    // x0 is never a real dependency, so it is masked even though sb[0] stays clear
    assign w_stall  = bus.validIn & (r_state == ST_RUN)
                    & ((r_sb[bus.rs1] & (bus.rs1 != 5'd0))
                     | (r_sb[bus.rs2] & (bus.rs2 != 5'd0)));
    assign w_accept = bus.validIn & (r_state == ST_RUN) & ~w_stall;

    // Set is applied after clear so a same-index collision leaves the bit set
    always_comb begin
        w_sb_next = r_sb;
        if (bus.loadDone) begin
            w_sb_next[bus.loadRd] = 1'b0;
        end
        if (w_accept & bus.isLoad & (bus.rd != 5'd0)) begin
            w_sb_next[bus.rd] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_squash_cnt <= 2'd0;
            r_sb         <= 32'd0;
            r_issue      <= 1'b0;
            r_origin     <= 1'b0;
            r_pc_branch  <= 32'd0;
            r_link       <= 32'd0;
            r_count      <= '0;
        end else begin
            r_issue  <= w_accept;
            r_origin <= w_accept & w_taken;
            r_sb     <= w_sb_next;
            if (w_accept) begin
                r_link <= bus.pcIn + 32'd4;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_accept & w_taken) begin
                        r_pc_branch  <= w_target;
                        r_count      <= r_count + 1'b1;
                        r_squash_cnt <= c_SQUASH_LOAD;
                        r_state      <= ST_SQUASH;
                    end
                end
                ST_SQUASH: begin
                    // Only instructions fetch actually delivers count toward the window
                    if (bus.validIn) begin
                        r_squash_cnt <= r_squash_cnt - 2'd1;
                        if (r_squash_cnt == 2'd1) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.stall         = w_stall;
    assign bus.originPc      = r_origin;
    assign bus.pcBranch      = r_pc_branch;
    assign bus.issueValid    = r_issue;
    assign bus.linkValue     = r_link;
    assign bus.redirectCount = r_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_resolve                                            |
// | Description : Vector table, corner sequences and random stimulus against   |
// |               a reference model of branch_resolve.                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_branch_resolve;
    localparam logic [6:0] c_OP_BR   = 7'h63;
    localparam logic [6:0] c_OP_JAL  = 7'h6F;
    localparam logic [6:0] c_OP_JALR = 7'h67;
    localparam logic [6:0] c_OP_LD   = 7'h03;
    localparam logic [6:0] c_OP_ALU  = 7'h33;
    localparam int         c_SQ1     = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(32), .CNTW(16)) bus ();
    branch_resolve_if #(.XLEN(32), .CNTW(3))  bus2 ();

    branch_resolve #(.XLEN(32), .SQUASH_DEPTH(1), .CNTW(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    branch_resolve #(.XLEN(32), .SQUASH_DEPTH(3), .CNTW(3))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b;
        bit          ld;
        logic [4:0]  ldrd;
        bit          e_stall, e_issue, e_origin;
        logic [31:0] e_pcb, e_link;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: outstanding loads, remaining wrong-path slots, last outputs
    logic [31:0] m_sb;
    int          m_squash;
    int          m_cnt;
    bit          m_issue, m_origin, m_stall;
    logic [31:0] m_pcb, m_link;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit valid, logic [31:0] pc, logic [6:0] op, logic [2:0] f3,
                                logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] a, logic [31:0] b, bit ld, logic [4:0] ldrd,
                                bit es, bit ei, bit eo, logic [31:0] epcb, logic [31:0] elink);
        vec_t v;
        v.valid = valid; v.pc = pc; v.op = op; v.f3 = f3; v.imm = imm;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.a = a; v.b = b; v.ld = ld; v.ldrd = ldrd;
        v.e_stall = es; v.e_issue = ei; v.e_origin = eo; v.e_pcb = epcb; v.e_link = elink;
        return v;
    endfunction

    function automatic bit ref_taken(logic [6:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        int s1, s2;
        s1 = int'(a);
        s2 = int'(b);
        if (op == c_OP_JAL || op == c_OP_JALR) return 1'b1;
        if (op != c_OP_BR) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return s1 < s2;
            3'd5:    return s1 >= s2;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_sb = 32'd0; m_squash = 0; m_cnt = 0;
        m_issue = 1'b0; m_origin = 1'b0; m_pcb = 32'd0; m_link = 32'd0;
    endfunction

    function automatic void model_step(vec_t v);
        bit acc, tk;
        acc = v.valid && (m_squash == 0) && !m_stall;
        tk  = acc && ref_taken(v.op, v.f3, v.a, v.b);
        if (v.valid && m_squash > 0) m_squash--;
        m_issue  = acc;
        m_origin = tk;
        if (acc) m_link = v.pc + 32'd4;
        if (tk) begin
            m_pcb    = (v.op == c_OP_JALR) ? ((v.a + v.imm) & ~32'd1) : (v.pc + v.imm);
            m_cnt    = (m_cnt + 1) % 65536;
            m_squash = c_SQ1;
        end
        if (v.ld) m_sb[v.ldrd] = 1'b0;
        if (acc && v.op == c_OP_LD && v.rd != 5'd0) m_sb[v.rd] = 1'b1;
    endfunction

    task automatic drive1(vec_t v);
        bus.validIn  = v.valid;
        bus.pcIn     = v.pc;
        bus.code     = {2'b00, v.f3, v.op};
        bus.imm      = v.imm;
        bus.rd       = v.rd;
        bus.rs1      = v.rs1;
        bus.rs2      = v.rs2;
        bus.isLoad   = (v.op == c_OP_LD);
        bus.isBranch = (v.op == c_OP_BR);
        bus.rs1Val   = v.a;
        bus.rs2Val   = v.b;
        bus.loadDone = v.ld;
        bus.loadRd   = v.ldrd;
    endtask

    task automatic apply(vec_t v, bit use_exp);
        @(negedge clk);
        drive1(v);
        #1;
        m_stall = v.valid && (m_squash == 0)
                && ((m_sb[v.rs1] && v.rs1 != 5'd0) || (m_sb[v.rs2] && v.rs2 != 5'd0));
        chk("stall", bus.stall, m_stall);
        if (use_exp) chk("tbl_stall", bus.stall, v.e_stall);
        model_step(v);
        @(posedge clk);
        #1;
        chk("issueValid", bus.issueValid, m_issue);
        chk("originPc", bus.originPc, m_origin);
        chk("redirectCount", bus.redirectCount, m_cnt);
        if (m_origin) chk("pcBranch", bus.pcBranch, m_pcb);
        if (m_issue) chk("linkValue", bus.linkValue, m_link);
        if (use_exp) begin
            chk("tbl_issueValid", bus.issueValid, v.e_issue);
            chk("tbl_originPc", bus.originPc, v.e_origin);
            if (v.e_origin) chk("tbl_pcBranch", bus.pcBranch, v.e_pcb);
            if (v.e_issue) chk("tbl_linkValue", bus.linkValue, v.e_link);
        end
    endtask

    // Reset is asserted with a taken branch on the bus to show it has priority
    task automatic do_reset();
        @(negedge clk);
        drive1(mk(1, 32'h10, c_OP_BR, 3'd0, 32'h20, 5'd0, 5'd1, 5'd2, 32'd5, 32'd5, 0, 5'd0,
                  0, 0, 0, 32'd0, 32'd0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_issueValid", bus.issueValid, 32'd0);
        chk("rst_originPc", bus.originPc, 32'd0);
        chk("rst_pcBranch", bus.pcBranch, 32'd0);
        chk("rst_linkValue", bus.linkValue, 32'd0);
        chk("rst_redirectCount", bus.redirectCount, 32'd0);
        chk("rst_stall", bus.stall, 32'd0);
    endtask

    task automatic drive2(bit valid, logic [6:0] op, logic [31:0] pc);
        bus2.validIn  = valid;
        bus2.code     = {5'd0, op};
        bus2.pcIn     = pc;
        bus2.imm      = 32'd8;
        bus2.isLoad   = 1'b0;
        bus2.isBranch = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = mk(0, 0, c_OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
            0, 1:    v.op = c_OP_BR;
            2:       v.op = c_OP_JAL;
            3:       v.op = c_OP_JALR;
            4:       v.op = c_OP_LD;
            default: v.op = c_OP_ALU;
        endcase
        v.f3   = 3'($urandom_range(0, 7));
        v.pc   = $urandom & 32'hFFFF_FFFC;
        v.imm  = $urandom;
        v.rd   = 5'($urandom_range(0, 7));
        v.rs1  = 5'($urandom_range(0, 7));
        v.rs2  = 5'($urandom_range(0, 7));
        v.a    = pick_val();
        v.b    = ($urandom_range(0, 2) == 0) ? v.a : pick_val();
        v.ld   = ($urandom_range(0, 4) == 0);
        v.ldrd = 5'($urandom_range(0, 7));
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        drive1(mk(0, 0, c_OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive2(0, c_OP_ALU, 32'd0);
        bus2.rd = 5'd0; bus2.rs1 = 5'd0; bus2.rs2 = 5'd0;
        bus2.rs1Val = 32'd0; bus2.rs2Val = 32'd0; bus2.loadDone = 1'b0; bus2.loadRd = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        //          v  pc        op         f3   imm           rd  rs1 rs2 a             b      ld ldrd  st is or pcb        link
        vt.push_back(mk(1, 32'h10,  c_OP_BR,   3'd0, 32'h20,       9, 1, 2, 32'd5,        32'd5, 0, 0,   0, 1, 1, 32'h30,  32'h14));
        vt.push_back(mk(1, 32'h14,  c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h18,  c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h1C));
        vt.push_back(mk(1, 32'h20,  c_OP_BR,   3'd4, 32'h100,      9, 1, 2, 32'hFFFFFFFF, 32'd1, 0, 0,   0, 1, 1, 32'h120, 32'h24));
        vt.push_back(mk(0, 32'h0,   c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h124, c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h120, c_OP_BR,   3'd6, 32'h100,      9, 1, 2, 32'hFFFFFFFF, 32'd1, 0, 0,   0, 1, 0, 32'h0,   32'h124));
        vt.push_back(mk(1, 32'h40,  c_OP_JALR, 3'd0, 32'h4,        9, 1, 2, 32'h101,      32'd0, 0, 0,   0, 1, 1, 32'h104, 32'h44));
        vt.push_back(mk(1, 32'h44,  c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h104, c_OP_LD,   3'd2, 32'h0,        7, 1, 0, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h108));
        vt.push_back(mk(1, 32'h108, c_OP_ALU,  3'd0, 32'h0,        9, 0, 7, 32'd0,        32'd0, 0, 0,   1, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h108, c_OP_ALU,  3'd0, 32'h0,        9, 0, 7, 32'd0,        32'd0, 0, 0,   1, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h108, c_OP_ALU,  3'd0, 32'h0,        9, 0, 7, 32'd0,        32'd0, 1, 7,   1, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h108, c_OP_ALU,  3'd0, 32'h0,        9, 0, 7, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h10C));
        vt.push_back(mk(1, 32'h10C, c_OP_LD,   3'd2, 32'h0,        3, 1, 2, 32'd0,        32'd0, 1, 3,   0, 1, 0, 32'h0,   32'h110));
        vt.push_back(mk(1, 32'h110, c_OP_ALU,  3'd0, 32'h0,        9, 3, 0, 32'd0,        32'd0, 0, 0,   1, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h110, c_OP_ALU,  3'd0, 32'h0,        9, 3, 0, 32'd0,        32'd0, 1, 3,   1, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h110, c_OP_ALU,  3'd0, 32'h0,        9, 3, 0, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h114));
        vt.push_back(mk(1, 32'h114, c_OP_LD,   3'd2, 32'h0,        0, 0, 0, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h118));
        vt.push_back(mk(1, 32'h118, c_OP_ALU,  3'd0, 32'h0,        9, 0, 0, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h11C));
        vt.push_back(mk(1, 32'h200, c_OP_JAL,  3'd0, 32'hFFFFFFF0, 1, 0, 0, 32'd0,        32'd0, 0, 0,   0, 1, 1, 32'h1F0, 32'h204));
        vt.push_back(mk(0, 32'h0,   c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h204, c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h1F0, c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 1, 0, 32'h0,   32'h1F4));
        vt.push_back(mk(1, 32'h300, c_OP_BR,   3'd1, 32'h8,        9, 1, 2, 32'd5,        32'd5, 0, 0,   0, 1, 0, 32'h0,   32'h304));
        vt.push_back(mk(1, 32'h304, c_OP_BR,   3'd5, 32'h40,       9, 1, 2, 32'hFFFFFFFF, 32'd1, 0, 0,   0, 1, 0, 32'h0,   32'h308));
        vt.push_back(mk(1, 32'h308, c_OP_BR,   3'd7, 32'h40,       9, 1, 2, 32'hFFFFFFFF, 32'd1, 0, 0,   0, 1, 1, 32'h348, 32'h30C));
        vt.push_back(mk(1, 32'h30C, c_OP_ALU,  3'd0, 32'h0,        9, 1, 2, 32'd0,        32'd0, 0, 0,   0, 0, 0, 32'h0,   32'h0));
        vt.push_back(mk(1, 32'h400, c_OP_BR,   3'd2, 32'h8,        9, 1, 2, 32'd5,        32'd5, 0, 0,   0, 1, 0, 32'h0,   32'h404));
        foreach (vt[i]) apply(vt[i], 1'b1);

        // Reset in the middle of a squash window also clears a pending load
        apply(mk(1, 32'h500, c_OP_LD, 3'd2, 32'h0, 5, 1, 2, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h504), 1'b1);
        apply(mk(1, 32'h504, c_OP_BR, 3'd0, 32'h10, 9, 1, 2, 7, 7, 0, 0, 0, 1, 1, 32'h514, 32'h508), 1'b1);
        @(negedge clk);
        drive1(mk(1, 32'h508, c_OP_ALU, 3'd0, 32'h0, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("sqrst_issueValid", bus.issueValid, 32'd0);
        chk("sqrst_originPc", bus.originPc, 32'd0);
        chk("sqrst_pcBranch", bus.pcBranch, 32'd0);
        chk("sqrst_redirectCount", bus.redirectCount, 32'd0);
        apply(mk(1, 32'h600, c_OP_ALU, 3'd0, 32'h0, 9, 5, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h604), 1'b1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else apply(rand_vec(), 1'b0);
        end

        // Deep squash window and narrow counter wrap on the second instance
        do_reset();
        drive1(mk(0, 0, c_OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            drive2(1'b1, c_OP_JAL, 32'(k * 16));
            @(posedge clk);
            #1;
            chk("w_originPc", bus2.originPc, 32'd1);
            chk("w_pcBranch", bus2.pcBranch, 32'(k * 16 + 8));
            chk("w_redirectCount", bus2.redirectCount, 32'(k % 8));
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                drive2(j != 1, c_OP_ALU, 32'h0);
                @(posedge clk);
                #1;
                chk("w_dropIssue", bus2.issueValid, 32'd0);
                chk("w_dropOrigin", bus2.originPc, 32'd0);
            end
        end
        @(negedge clk);
        drive2(1'b1, c_OP_ALU, 32'h80);
        @(posedge clk);
        #1;
        chk("w_resumeIssue", bus2.issueValid, 32'd1);
        chk("w_resumeLink", bus2.linkValue, 32'h84);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
